// File: rtl/picosoc_io_pkg.sv
// Shared definitions for the PicoSoC memory-mapped IO blocks:
// sequencer state encoding, register offsets (iomem_addr[3:2]) and
// CTRL/STATUS bit positions, plus a byte-strobe to bit-mask helper.
package picosoc_io_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CHARGE = 2'd1,
    ST_SENSE  = 2'd2,
    ST_DONE   = 2'd3
  } sense_state_t;

  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_RESULT = 2'd2;
  localparam logic [1:0] REG_LIMIT  = 2'd3;

  localparam int CTRL_START      = 0;
  localparam int CTRL_CONT       = 1;
  localparam int CTRL_IDLE_DRIVE = 2;

  localparam int STAT_BUSY    = 0;
  localparam int STAT_DONE    = 1;
  localparam int STAT_TIMEOUT = 2;

  // Expand 4 byte strobes into a 32-bit write mask.
  function automatic logic [31:0] strb_mask(input logic [3:0] strb);
    logic [31:0] m;
    for (int b = 0; b < 4; b++) begin
      m[b*8 +: 8] = {8{strb[b]}};
    end
    return m;
  endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for a single asynchronous level.
// Ports: clock, resetn (synchronous, active-low), d (async in), q (synced out).
// Both flops reset to 1 so an idle-high pad reads as "not discharged".
module sync2 (
  input  logic clock,
  input  logic resetn,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clock) begin
    if (!resetn) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/led_sense_ctrl.sv
// LED-as-light-sensor sequencer: charge the pad, release it, time the discharge.
// Ports: iomem_* single-cycle-ack register bus (page ADDR_PAGE), pin_oe/pin_do/pin_di pad.
// Optional: define LED_SENSE_AVG_EN to average 4 passes per start (RESULT = sum >> 2).
module led_sense_ctrl
  import picosoc_io_pkg::*;
#(
  parameter logic [7:0] ADDR_PAGE     = 8'h09,
  parameter int         CHARGE_CYCLES = 32,
  parameter int         CNT_W         = 16
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic        iomem_valid,
  output logic        iomem_ready,
  input  logic [3:0]  iomem_wstrb,
  input  logic [31:0] iomem_addr,
  input  logic [31:0] iomem_wdata,
  output logic [31:0] iomem_rdata,
  output logic        pin_oe,
  output logic        pin_do,
  input  logic        pin_di
);

  localparam int CHG_W = $clog2(CHARGE_CYCLES) + 1;

  sense_state_t     state, state_nxt;
  logic [CHG_W-1:0] chg_cnt;
  logic [CNT_W-1:0] count, limit, result, meas_val;
  logic             cont, idle_drive, done, timeout;
  logic             di_sync;
  logic             acc, wr, start_req;
  logic [1:0]       off;
  logic [31:0]      mask, rd_val;
  logic             hit_limit, sense_end, last_pass;
  logic             oe_nxt, do_nxt;
  logic             unused_bits;

  assign unused_bits = &{1'b0, iomem_addr[23:4], iomem_addr[1:0], iomem_wdata, mask};

  sync2 u_sync (.clock(clock), .resetn(resetn), .d(pin_di), .q(di_sync));

  // A request is taken only while ready is low, so a held valid yields
  // ready pulses separated by at least one idle cycle.
  assign acc       = iomem_valid && !iomem_ready && (iomem_addr[31:24] == ADDR_PAGE);
  assign wr        = acc && (iomem_wstrb != 4'b0000);
  assign off       = iomem_addr[3:2];
  assign mask      = strb_mask(iomem_wstrb);
  assign start_req = wr && (off == REG_CTRL) && iomem_wstrb[0] && iomem_wdata[CTRL_START];

  // >= rather than == so a LIMIT lowered below the running count still
  // terminates the pass and the counter can never wrap.
  assign hit_limit = (count >= limit);
  assign sense_end = (state == ST_SENSE) && (hit_limit || !di_sync);

`ifdef LED_SENSE_AVG_EN
  logic [1:0]       pass;
  logic [CNT_W+1:0] sum, sum_nxt;

  assign sum_nxt   = sum + (CNT_W+2)'(hit_limit ? limit : count);
  assign last_pass = (pass == 2'd3);
  assign meas_val  = CNT_W'(sum_nxt >> 2);

  always_ff @(posedge clock) begin
    if (!resetn) begin
      pass <= 2'd0;
      sum  <= '0;
    end else if (sense_end) begin
      if (last_pass) begin
        pass <= 2'd0;
        sum  <= '0;
      end else begin
        pass <= pass + 2'd1;
        sum  <= sum_nxt;
      end
    end
  end
`else
  assign last_pass = 1'b1;
  assign meas_val  = hit_limit ? limit : count;
`endif

  always_ff @(posedge clock) begin
    if (!resetn) state <= ST_IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    oe_nxt    = 1'b0;
    do_nxt    = 1'b0;
    case (state)
      ST_IDLE:   if (start_req) state_nxt = ST_CHARGE;
      ST_CHARGE: if (chg_cnt == CHG_W'(CHARGE_CYCLES - 1)) state_nxt = ST_SENSE;
      ST_SENSE:  if (sense_end) state_nxt = last_pass ? ST_DONE : ST_CHARGE;
      ST_DONE:   state_nxt = cont ? ST_CHARGE : ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
    // Pad controls are registered from the next state so they line up
    // exactly with the state they belong to.
    case (state_nxt)
      ST_IDLE:   begin oe_nxt = idle_drive; do_nxt = 1'b1; end
      ST_CHARGE: begin oe_nxt = 1'b1;       do_nxt = 1'b1; end
      default:   begin oe_nxt = 1'b0;       do_nxt = 1'b0; end
    endcase
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      pin_oe  <= 1'b0;
      pin_do  <= 1'b0;
      chg_cnt <= '0;
      count   <= '0;
    end else begin
      pin_oe  <= oe_nxt;
      pin_do  <= do_nxt;
      chg_cnt <= (state == ST_CHARGE) ? chg_cnt + CHG_W'(1) : '0;
      if (state != ST_SENSE) count <= '0;
      else if (!hit_limit)   count <= count + CNT_W'(1);
    end
  end

  // Registers. Sticky-bit clears are written before the set so a set
  // event in the same cycle overrides the clear.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      cont       <= 1'b0;
      idle_drive <= 1'b0;
      done       <= 1'b0;
      timeout    <= 1'b0;
      result     <= '0;
      limit      <= '1;
    end else begin
      if (wr && (off == REG_CTRL) && iomem_wstrb[0]) begin
        cont       <= iomem_wdata[CTRL_CONT];
        idle_drive <= iomem_wdata[CTRL_IDLE_DRIVE];
      end
      if (wr && (off == REG_LIMIT))
        limit <= (limit & ~mask[CNT_W-1:0]) | (iomem_wdata[CNT_W-1:0] & mask[CNT_W-1:0]);
      if (wr && (off == REG_STATUS) && iomem_wstrb[0]) begin
        if (iomem_wdata[STAT_DONE])    done    <= 1'b0;
        if (iomem_wdata[STAT_TIMEOUT]) timeout <= 1'b0;
      end
      if (sense_end) begin
        if (hit_limit) timeout <= 1'b1;
        if (last_pass) begin
          done   <= 1'b1;
          result <= meas_val;
        end
      end
    end
  end

  always_comb begin
    rd_val = '0;
    case (off)
      REG_CTRL: begin
        rd_val[CTRL_CONT]       = cont;
        rd_val[CTRL_IDLE_DRIVE] = idle_drive;
      end
      REG_STATUS: begin
        rd_val[STAT_BUSY]    = (state != ST_IDLE);
        rd_val[STAT_DONE]    = done;
        rd_val[STAT_TIMEOUT] = timeout;
      end
      REG_RESULT: rd_val = 32'(result);
      default:    rd_val = 32'(limit);
    endcase
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      iomem_ready <= 1'b0;
      iomem_rdata <= '0;
    end else begin
      iomem_ready <= acc;
      if (acc) iomem_rdata <= rd_val;
    end
  end

endmodule

// File: tb/tb_led_sense_ctrl.sv
// Testbench for led_sense_ctrl: randomized and directed measurements checked
// against an arithmetic model of the discharge timing (2-cycle sync latency).
module tb_led_sense_ctrl;

  localparam int CC = 32;

  logic        clock = 1'b0;
  logic        resetn;
  logic        iomem_valid;
  logic        iomem_ready;
  logic [3:0]  iomem_wstrb;
  logic [31:0] iomem_addr;
  logic [31:0] iomem_wdata;
  logic [31:0] iomem_rdata;
  logic        pin_oe, pin_do, pin_di;

  int vectors = 0;
  int miscompares = 0;
  int oe_rises = 0;
  logic oe_q = 1'b0;

  led_sense_ctrl #(.ADDR_PAGE(8'h09), .CHARGE_CYCLES(CC), .CNT_W(16)) dut (
    .clock(clock), .resetn(resetn),
    .iomem_valid(iomem_valid), .iomem_ready(iomem_ready), .iomem_wstrb(iomem_wstrb),
    .iomem_addr(iomem_addr), .iomem_wdata(iomem_wdata), .iomem_rdata(iomem_rdata),
    .pin_oe(pin_oe), .pin_do(pin_do), .pin_di(pin_di)
  );

  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (pin_oe && !oe_q) oe_rises = oe_rises + 1;
    oe_q = pin_oe;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached, required finish");
    $fatal(1);
  end

  // Reference: the pad is seen low two cycles after it drops; the pass ends at
  // whichever of (drop+2) or LIMIT comes first, a tie counting as timeout.
  function automatic void model(input int drop, input int lim, output int res, output bit to);
    if (drop >= 0 && drop + 2 < lim) begin res = drop + 2; to = 1'b0; end
    else                             begin res = lim;      to = 1'b1; end
  endfunction

  task automatic bus(input logic [7:0] page, input logic [1:0] off, input logic [3:0] strb,
                     input logic [31:0] wd, output logic [31:0] rd);
    bit ok = 1'b0;
    rd = 32'hx;
    iomem_valid = 1'b1;
    iomem_addr  = {page, 20'h0, off, 2'b00};
    iomem_wstrb = strb;
    iomem_wdata = wd;
    for (int i = 0; i < 8 && !ok; i++) begin
      @(posedge clock); #1;
      if (iomem_ready) begin rd = iomem_rdata; ok = 1'b1; end
    end
    iomem_valid = 1'b0;
    iomem_wstrb = 4'h0;
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL bus_ack: ready=0 after 8 cycles, required 1 (off %0d)", off);
    end
  endtask

  task automatic reg_wr(input logic [1:0] off, input logic [31:0] d);
    logic [31:0] dummy;
    bus(8'h09, off, 4'hF, d, dummy);
  endtask

  task automatic reg_rd(input logic [1:0] off, output logic [31:0] d);
    bus(8'h09, off, 4'h0, 32'h0, d);
  endtask

  task automatic wait_idle();
    logic [31:0] s;
    bit idle = 1'b0;
    for (int i = 0; i < 1000 && !idle; i++) begin
      reg_rd(2'd1, s);
      idle = !s[0];
    end
    vectors++;
    if (!idle) begin
      miscompares++;
      $display("FAIL wait_idle: busy=1 after 1000 polls, required 0");
    end
  endtask

  task automatic wait_oe(input logic level);
    int n = 0;
    while (pin_oe !== level && n < 200) begin @(posedge clock); #1; n++; end
    vectors++;
    if (pin_oe !== level) begin
      miscompares++;
      $display("FAIL wait_oe: pin_oe=%b after 200 cycles, required %b", pin_oe, level);
    end
  endtask

  // One measurement: drop < 0 keeps the pad high (forces timeout).
  task automatic do_meas(input int lim, input int drop, output int hi);
    reg_wr(2'd3, lim);
    reg_wr(2'd0, 32'h1);
    wait_oe(1'b1);
    hi = 0;
    while (pin_oe && hi < 200) begin hi++; @(posedge clock); #1; end
    if (drop >= 0) begin
      repeat (drop) begin @(posedge clock); #1; end
      pin_di = 1'b0;
    end
    wait_idle();
    pin_di = 1'b1;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    resetn = 1'b0; pin_di = 1'b1; iomem_valid = 1'b0;
    iomem_wstrb = 4'h0; iomem_addr = 32'h0; iomem_wdata = 32'h0;
    repeat (3) @(posedge clock);
    #1;
    vectors++;
    if ({iomem_ready, iomem_rdata, pin_oe, pin_do} !== 35'h0) begin
      miscompares++;
      $display("FAIL reset_outputs: ready=%b rdata=%h oe=%b do=%b, required all 0",
               iomem_ready, iomem_rdata, pin_oe, pin_do);
    end
    resetn = 1'b1;
    @(posedge clock); #1;
    vectors++;
    if (pin_do !== 1'b1 || pin_oe !== 1'b0) begin
      miscompares++;
      $display("FAIL idle_pins: oe=%b do=%b, required oe=0 do=1", pin_oe, pin_do);
    end
    reg_rd(2'd3, d);
    vectors++;
    if (d !== 32'h0000_FFFF) begin miscompares++; $display("FAIL reset_limit: got %h, required 0000ffff", d); end
    reg_rd(2'd1, d);
    vectors++;
    if (d !== 32'h0) begin miscompares++; $display("FAIL reset_status: got %h, required 0", d); end
    reg_rd(2'd2, d);
    vectors++;
    if (d !== 32'h0) begin miscompares++; $display("FAIL reset_result: got %h, required 0", d); end
  endtask

  task automatic test_wstrb();
    logic [31:0] d, dummy;
    bus(8'h09, 2'd3, 4'b0001, 32'h1234_5678, dummy);
    reg_rd(2'd3, d);
    vectors++;
    if (d !== 32'h0000_FF78) begin miscompares++; $display("FAIL limit_wstrb: got %h, required 0000ff78", d); end
    reg_wr(2'd0, 32'hFFFF_FFF6);
    reg_rd(2'd0, d);
    vectors++;
    if (d !== 32'h6) begin miscompares++; $display("FAIL ctrl_readback: got %h, required 00000006", d); end
    reg_wr(2'd0, 32'h0);
    reg_wr(2'd3, 32'hFFFF);
  endtask

  task automatic test_bus_pages();
    int pulses = 0;
    bit back2back = 1'b0;
    logic prev = 1'b0;
    iomem_valid = 1'b1; iomem_wstrb = 4'h0; iomem_addr = 32'h0300_0004;
    repeat (8) begin
      @(posedge clock); #1;
      if (iomem_ready) pulses++;
    end
    vectors++;
    if (pulses != 0) begin miscompares++; $display("FAIL foreign_page: %0d ready pulses, required 0", pulses); end
    iomem_addr = 32'h0900_0004;
    pulses = 0;
    repeat (8) begin
      @(posedge clock); #1;
      if (iomem_ready) begin pulses++; if (prev) back2back = 1'b1; end
      prev = iomem_ready;
    end
    iomem_valid = 1'b0;
    @(posedge clock); #1;
    vectors++;
    if (pulses != 4 || back2back) begin
      miscompares++;
      $display("FAIL back_to_back: pulses=%0d adjacent=%b, required 4 and 0", pulses, back2back);
    end
  endtask

`ifndef LED_SENSE_AVG_EN
  task automatic test_single();
    logic [31:0] d;
    int hi;
    do_meas(1000, 50, hi);
    vectors++;
    if (hi != CC) begin miscompares++; $display("FAIL charge_len: got %0d, required %0d", hi, CC); end
    reg_rd(2'd2, d);
    vectors++;
    if (d !== 32'd52) begin miscompares++; $display("FAIL single_result: got %0d, required 52", d); end
    reg_rd(2'd1, d);
    vectors++;
    if (d !== 32'h2) begin miscompares++; $display("FAIL single_status: got %h, required 2", d); end
    reg_wr(2'd1, 32'h6);
  endtask

  task automatic test_timeout();
    logic [31:0] d;
    int hi;
    do_meas(100, -1, hi);
    reg_rd(2'd2, d);
    vectors++;
    if (d !== 32'd100) begin miscompares++; $display("FAIL timeout_result: got %0d, required 100", d); end
    reg_rd(2'd1, d);
    vectors++;
    if (d !== 32'h6) begin miscompares++; $display("FAIL timeout_status: got %h, required 6", d); end
    reg_wr(2'd1, 32'h2);
    reg_rd(2'd1, d);
    vectors++;
    if (d !== 32'h4) begin miscompares++; $display("FAIL w1c_done_only: got %h, required 4", d); end
    reg_wr(2'd1, 32'h6);
    reg_rd(2'd1, d);
    vectors++;
    if (d !== 32'h0) begin miscompares++; $display("FAIL w1c_both: got %h, required 0", d); end
  endtask

  task automatic test_limit_zero();
    logic [31:0] r, s;
    int hi;
    do_meas(0, -1, hi);
    reg_rd(2'd2, r);
    reg_rd(2'd1, s);
    vectors++;
    if (r !== 32'h0 || s !== 32'h6) begin
      miscompares++;
      $display("FAIL limit_zero: result=%h status=%h, required 0 and 6", r, s);
    end
    reg_wr(2'd1, 32'h6);
  endtask

  task automatic test_random();
    logic [31:0] r, s;
    int hi, drop, lim, exp_res;
    bit exp_to;
    for (int k = 0; k < 8; k++) begin
      drop = $urandom_range(0, 120);
      lim  = $urandom_range(1, 130);
      model(drop, lim, exp_res, exp_to);
      do_meas(lim, drop, hi);
      reg_rd(2'd2, r);
      reg_rd(2'd1, s);
      vectors++;
      if (r !== 32'(exp_res) || s !== {29'h0, exp_to, 2'b10}) begin
        miscompares++;
        $display("FAIL random drop=%0d lim=%0d: result=%0d status=%h, required %0d and %h",
                 drop, lim, r, s, exp_res, {29'h0, exp_to, 2'b10});
      end
      reg_wr(2'd1, 32'h6);
    end
  endtask

  task automatic test_start_while_busy();
    logic [31:0] r, s;
    int base, hi;
    base = oe_rises;
    reg_wr(2'd3, 80);
    reg_wr(2'd0, 32'h1);
    wait_oe(1'b1);
    wait_oe(1'b0);
    repeat (5) begin @(posedge clock); #1; end
    reg_wr(2'd0, 32'h1);
    wait_idle();
    repeat (100) begin @(posedge clock); #1; end
    reg_rd(2'd2, r);
    reg_rd(2'd1, s);
    hi = oe_rises - base;
    vectors++;
    if (r !== 32'd80 || s !== 32'h6 || hi != 1) begin
      miscompares++;
      $display("FAIL start_busy: result=%0d status=%h charges=%0d, required 80, 6, 1", r, s, hi);
    end
    reg_wr(2'd1, 32'h6);
  endtask

  task automatic test_continuous();
    logic [31:0] r, s;
    int base, n;
    base = oe_rises;
    reg_wr(2'd3, 40);
    reg_wr(2'd0, 32'h7);
    n = 0;
    while (oe_rises - base < 2 && n < 300) begin @(posedge clock); #1; n++; end
    vectors++;
    if (oe_rises - base < 2) begin miscompares++; $display("FAIL cont_second_charge: rises=%0d, required 2", oe_rises - base); end
    reg_wr(2'd0, 32'h4);
    wait_idle();
    repeat (100) begin @(posedge clock); #1; end
    reg_rd(2'd2, r);
    reg_rd(2'd1, s);
    vectors++;
    if (r !== 32'd40 || s !== 32'h6 || pin_oe !== 1'b1 || oe_rises - base != 3) begin
      miscompares++;
      $display("FAIL cont_stop: result=%0d status=%h oe=%b rises=%0d, required 40, 6, 1, 3",
               r, s, pin_oe, oe_rises - base);
    end
    reg_wr(2'd0, 32'h0);
    @(posedge clock); #1;
    vectors++;
    if (pin_oe !== 1'b0) begin miscompares++; $display("FAIL idle_drive_off: oe=%b, required 0", pin_oe); end
    reg_wr(2'd1, 32'h6);
  endtask
`else
  task automatic test_avg();
    logic [31:0] r, s;
    int drops[4] = '{38, 42, 46, 50};
    reg_wr(2'd3, 1000);
    reg_wr(2'd0, 32'h1);
    for (int p = 0; p < 4; p++) begin
      wait_oe(1'b1);
      wait_oe(1'b0);
      repeat (drops[p]) begin @(posedge clock); #1; end
      pin_di = 1'b0;
      repeat (3) begin @(posedge clock); #1; end
      pin_di = 1'b1;
      if (p < 3) begin
        reg_rd(2'd1, s);
        vectors++;
        if (s[1] !== 1'b0) begin miscompares++; $display("FAIL avg_early_done pass %0d: done=%b, required 0", p, s[1]); end
      end
    end
    wait_idle();
    reg_rd(2'd2, r);
    reg_rd(2'd1, s);
    vectors++;
    if (r !== 32'd46 || s !== 32'h2) begin
      miscompares++;
      $display("FAIL avg_result: result=%0d status=%h, required 46 and 2", r, s);
    end
    reg_wr(2'd1, 32'h6);
  endtask
`endif

  task automatic test_reset_abort();
    logic [31:0] r, s;
    reg_wr(2'd3, 1000);
    reg_wr(2'd0, 32'h1);
    wait_oe(1'b1);
    wait_oe(1'b0);
    repeat (10) begin @(posedge clock); #1; end
    resetn = 1'b0;
    @(posedge clock); #1;
    resetn = 1'b1;
    @(posedge clock); #1;
    reg_rd(2'd1, s);
    reg_rd(2'd2, r);
    vectors++;
    if (s !== 32'h0 || r !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_abort: status=%h result=%h, required 0 and 0", s, r);
    end
  endtask

  initial begin
    test_reset();
    test_wstrb();
    test_bus_pages();
`ifndef LED_SENSE_AVG_EN
    test_single();
    test_timeout();
    test_limit_zero();
    test_random();
    test_start_while_busy();
    test_continuous();
`else
    test_avg();
`endif
    test_reset_abort();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
